udma_mram_cfg_seq: RTL and testbench
====================================

Name: udma_mram_cfg_seq

Overview:
- Configuration-bus initiator for the uDMA MRAM peripheral register file.
- Accepts one high-level command (READ, PROG or ERASE) and issues the register writes that program and start the transfer.
- Polls MRAM_STATUS until the operation finishes, then reads ISR and writes the same bits to ICR to clear it.
- Returns a one-beat response. Lets a small controller or debug master run MRAM operations without software sequencing.

Parameters:
- L2_AWIDTH_NOAL, 12, L2 start-address width.
- TRANS_SIZE, 16, transfer-size width.
- MRAM_ADDR_WIDTH, 20, MRAM destination-address width.
- POLL_GAP, 8, idle cycles between STATUS reads (range 1..255).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_op_i  in  2  0=READ, 1=PROG, 2=ERASE, 3=reserved.
- cmd_l2_addr_i  in  L2_AWIDTH_NOAL  L2 start address.
- cmd_mram_addr_i  in  MRAM_ADDR_WIDTH  MRAM address; ERASE uses bits [15:0].
- cmd_size_i  in  TRANS_SIZE  byte count; ERASE uses bits [9:0] as erase size.
- cmd_mode_i  in  32  value written to MODE.
- timeout_limit_i  in  16  max STATUS reads; sampled at command accept.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_status_o  out  8  {err_op, timeout, ecc[1:0], isr[3:0]}.
- busy_o  out  1  high in every state except IDLE.
- cfg_data_o  out  32  write data.
- cfg_addr_o  out  5  register word address.
- cfg_valid_o  out  1  access request.
- cfg_rwn_o  out  1  1=read, 0=write.
- cfg_data_i  in  32  read data.
- cfg_ready_i  in  1  access complete.

Behaviour:
- Reset values: all outputs 0, except cmd_ready_o=1. FSM in IDLE.
- Register map (word addresses): RX_SADDR 0x00, RX_SIZE 0x01, RX_CFG 0x02, TX_SADDR 0x04, TX_SIZE 0x05, TX_CFG 0x06, TX_DADDR 0x08, RX_DADDR 0x09, STATUS 0x0A, MODE 0x0B, ERASE_ADDR 0x0C, ERASE_SIZE 0x0D, TRIGGER 0x0F, ISR 0x10, ICR 0x12.
- cfg handshake:
  - cfg_valid_o, cfg_addr_o, cfg_rwn_o and cfg_data_o are registered and held stable until a cycle with cfg_ready_i=1.
  - Read data is captured in that same cycle.
  - The next access may start the following cycle.
  - Unused cfg_data_o is 0 on reads.
- IDLE:
  - cmd_ready_o=1.
  - On accept, all command fields are latched, cmd_ready_o drops, and the timeout counter and response are cleared.
  - The first access is presented the next cycle.
  - op=3: no bus access; go to RSP with err_op=1.
- Write sequences:
  - READ: MODE, RX_SADDR, RX_SIZE, RX_DADDR, RX_CFG=0x10.
  - PROG: MODE, TX_SADDR, TX_SIZE, TX_DADDR, TX_CFG=0x10.
  - ERASE: MODE, ERASE_ADDR={16'h0,addr[15:0]}, ERASE_SIZE={22'h0,size[9:0]}, TRIGGER=1.
  - Address and size values are zero-extended to 32 bits.
- POLL_WAIT: count POLL_GAP cycles, then go to POLL_RD.
- POLL_RD: read STATUS.
  - Busy bit: READ=bit2, PROG=bit1, ERASE=bit0.
  - Capture ecc=STATUS[5:4] on every read.
  - Busy=1: increment the poll counter and return to POLL_WAIT.
  - Busy=0: go to RD_ISR.
- RD_ISR: read ISR and capture isr=data[3:0].
- WR_ICR: write ICR={28'h0,isr}, then go to RSP.
- RSP:
  - rsp_valid_o=1 with rsp_status_o stable.
  - On rsp_ready_i, go to IDLE and set cmd_ready_o=1 the next cycle.
  - Back-to-back commands are allowed.
- Total latency (READ/PROG/ERASE) with zero-wait cfg and an immediately idle STATUS: 5 writes + POLL_GAP + 1 poll + ISR + ICR.
- cmd_valid_i is ignored while busy.
- Reset mid-operation clears everything at once, including cfg_valid_o.

Optional Feature:
- Macro: MRAM_CFG_SEQ_TIMEOUT_EN.
- Defined:
  - When the poll counter equals timeout_limit_i and busy is still 1, go to ABORT.
  - ABORT writes the clear bit to the relevant channel: RX_CFG=0x40 or TX_CFG=0x40. ERASE skips the write.
  - Then RD_ISR/WR_ICR run as normal, and rsp_status_o[6]=1.
  - timeout_limit_i=0 disables the timeout.
- Undefined:
  - Polling continues indefinitely.
  - timeout_limit_i is ignored.
  - rsp_status_o[6] is tied to 0.

Test Plan:
- PROG, l2=0x100, mram=0x01234, size=0x40, mode=0x2, STATUS idle at first poll -> writes in order: 0x0B=0x2, 0x04=0x100, 0x05=0x40, 0x08=0x01234, 0x06=0x10. Then read 0x0A, read 0x10 (returns 0x2), write 0x12=0x2. rsp_status_o=0x02.
- READ with STATUS bit2 high for 3 polls and STATUS[5:4]=2'b01 -> 4 STATUS reads spaced POLL_GAP cycles apart; rsp_status_o[5:4]=01.
- ERASE, addr=0xABCD, size=0x3FF, cfg_ready_i delayed 3 cycles per access -> each request held stable 4 cycles; writes 0x0C=0xABCD, 0x0D=0x3FF, 0x0F=1.
- op=3 -> no cfg_valid_o pulses; rsp_status_o=0x80 one cycle after accept.
- With MRAM_CFG_SEQ_TIMEOUT_EN, PROG, timeout_limit_i=2, STATUS busy forever -> 2 polls, then write 0x06=0x40, ISR read, ICR write; rsp_status_o[6]=1.
- Reset asserted during POLL_WAIT -> cfg_valid_o=0 and cmd_ready_o=1 at once; a new command then completes normally.

Source files
------------

// File: rtl/udma_mram_cfg_seq.sv
// Configuration-bus sequencer for the uDMA MRAM register file: programs a READ/PROG/ERASE,
// polls STATUS, clears ISR via ICR and returns a one-beat response. Optional: MRAM_CFG_SEQ_TIMEOUT_EN.
module udma_mram_cfg_seq #(
    parameter int L2_AWIDTH_NOAL  = 12,
    parameter int TRANS_SIZE      = 16,
    parameter int MRAM_ADDR_WIDTH = 20,
    parameter int POLL_GAP        = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [1:0]                 cmd_op_i,
    input  logic [L2_AWIDTH_NOAL-1:0]  cmd_l2_addr_i,
    input  logic [MRAM_ADDR_WIDTH-1:0] cmd_mram_addr_i,
    input  logic [TRANS_SIZE-1:0]      cmd_size_i,
    input  logic [31:0]                cmd_mode_i,
    input  logic [15:0]                timeout_limit_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [7:0]                 rsp_status_o,
    output logic                       busy_o,
    output logic [31:0]                cfg_data_o,
    output logic [4:0]                 cfg_addr_o,
    output logic                       cfg_valid_o,
    output logic                       cfg_rwn_o,
    input  logic [31:0]                cfg_data_i,
    input  logic                       cfg_ready_i
);

    localparam logic [4:0] REG_RX_SADDR   = 5'h00;
    localparam logic [4:0] REG_RX_SIZE    = 5'h01;
    localparam logic [4:0] REG_RX_CFG     = 5'h02;
    localparam logic [4:0] REG_TX_SADDR   = 5'h04;
    localparam logic [4:0] REG_TX_SIZE    = 5'h05;
    localparam logic [4:0] REG_TX_CFG     = 5'h06;
    localparam logic [4:0] REG_TX_DADDR   = 5'h08;
    localparam logic [4:0] REG_RX_DADDR   = 5'h09;
    localparam logic [4:0] REG_STATUS     = 5'h0A;
    localparam logic [4:0] REG_MODE       = 5'h0B;
    localparam logic [4:0] REG_ERASE_ADDR = 5'h0C;
    localparam logic [4:0] REG_ERASE_SIZE = 5'h0D;
    localparam logic [4:0] REG_TRIGGER    = 5'h0F;
    localparam logic [4:0] REG_ISR        = 5'h10;
    localparam logic [4:0] REG_ICR        = 5'h12;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_PROG  = 2'd1;
    localparam logic [1:0] OP_ERASE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [31:0] CFG_EN    = 32'h10;
    localparam logic [31:0] CFG_CLR   = 32'h40;
    localparam logic [7:0]  GAP_LAST  = 8'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_POLL_WAIT, S_POLL_RD, S_ABORT, S_RD_ISR, S_WR_ICR, S_RSP
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 op_q, op_d;
    logic [L2_AWIDTH_NOAL-1:0]  l2_q, l2_d;
    logic [MRAM_ADDR_WIDTH-1:0] mram_q, mram_d;
    logic [TRANS_SIZE-1:0]      size_q, size_d;
    logic [2:0]                 step_q, step_d;
    logic [7:0]                 gap_q, gap_d;
    logic [15:0]                poll_q, poll_d;
    logic                       cfg_valid_q, cfg_valid_d;
    logic                       cfg_rwn_q, cfg_rwn_d;
    logic [4:0]                 cfg_addr_q, cfg_addr_d;
    logic [31:0]                cfg_data_q, cfg_data_d;
    logic                       err_op_q, err_op_d;
    logic                       timeout_q, timeout_d;
    logic [1:0]                 ecc_q, ecc_d;
    logic [3:0]                 isr_q, isr_d;

    logic [2:0]  step_nxt;
    logic [2:0]  last_step;
    logic [4:0]  seq_addr;
    logic [31:0] seq_data;
    logic        is_erase;
    logic        status_busy;
    logic [15:0] poll_inc;
    logic        timeout_hit;

    assign is_erase  = (op_q == OP_ERASE);
    assign last_step = is_erase ? 3'd3 : 3'd4;
    assign step_nxt  = step_q + 3'd1;
    assign poll_inc  = poll_q + 16'd1;

`ifdef MRAM_CFG_SEQ_TIMEOUT_EN
    logic [15:0] limit_q, limit_d;
    // A zero limit means poll forever.
    assign timeout_hit = (limit_q != 16'd0) && (poll_inc == limit_q);
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^timeout_limit_i;
`endif

    logic unused_cfg_data;
    assign unused_cfg_data = ^cfg_data_i[31:6];

    always_comb begin
        case (op_q)
            OP_READ:  status_busy = cfg_data_i[2];
            OP_PROG:  status_busy = cfg_data_i[1];
            default:  status_busy = cfg_data_i[0];
        endcase
    end

    // Register/value of the write that follows the current one in the programming sequence.
    always_comb begin
        seq_addr = REG_MODE;
        seq_data = 32'h0;
        case (step_nxt)
            3'd1: begin
                seq_addr = is_erase ? REG_ERASE_ADDR : (op_q == OP_READ ? REG_RX_SADDR : REG_TX_SADDR);
                seq_data = is_erase ? 32'(mram_q[15:0]) : 32'(l2_q);
            end
            3'd2: begin
                seq_addr = is_erase ? REG_ERASE_SIZE : (op_q == OP_READ ? REG_RX_SIZE : REG_TX_SIZE);
                seq_data = is_erase ? 32'(size_q[9:0]) : 32'(size_q);
            end
            3'd3: begin
                seq_addr = is_erase ? REG_TRIGGER : (op_q == OP_READ ? REG_RX_DADDR : REG_TX_DADDR);
                seq_data = is_erase ? 32'h1 : 32'(mram_q);
            end
            3'd4: begin
                seq_addr = (op_q == OP_READ) ? REG_RX_CFG : REG_TX_CFG;
                seq_data = CFG_EN;
            end
            default: ;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        l2_d        = l2_q;
        mram_d      = mram_q;
        size_d      = size_q;
        step_d      = step_q;
        gap_d       = gap_q;
        poll_d      = poll_q;
        cfg_valid_d = cfg_valid_q;
        cfg_rwn_d   = cfg_rwn_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;
        err_op_d    = err_op_q;
        timeout_d   = timeout_q;
        ecc_d       = ecc_q;
        isr_d       = isr_q;
`ifdef MRAM_CFG_SEQ_TIMEOUT_EN
        limit_d     = limit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d      = cmd_op_i;
                    l2_d      = cmd_l2_addr_i;
                    mram_d    = cmd_mram_addr_i;
                    size_d    = cmd_size_i;
`ifdef MRAM_CFG_SEQ_TIMEOUT_EN
                    limit_d   = timeout_limit_i;
`endif
                    step_d    = 3'd0;
                    gap_d     = 8'd0;
                    poll_d    = 16'd0;
                    err_op_d  = 1'b0;
                    timeout_d = 1'b0;
                    ecc_d     = 2'b00;
                    isr_d     = 4'h0;
                    if (cmd_op_i == OP_RSVD) begin
                        err_op_d = 1'b1;
                        state_d  = S_RSP;
                    end else begin
                        cfg_valid_d = 1'b1;
                        cfg_rwn_d   = 1'b0;
                        cfg_addr_d  = REG_MODE;
                        cfg_data_d  = cmd_mode_i;
                        state_d     = S_WR;
                    end
                end
            end
            S_WR: begin
                if (cfg_ready_i) begin
                    if (step_q == last_step) begin
                        cfg_valid_d = 1'b0;
                        cfg_data_d  = 32'h0;
                        gap_d       = 8'd0;
                        state_d     = S_POLL_WAIT;
                    end else begin
                        step_d     = step_nxt;
                        cfg_addr_d = seq_addr;
                        cfg_data_d = seq_data;
                    end
                end
            end
            S_POLL_WAIT: begin
                if (gap_q == GAP_LAST) begin
                    cfg_valid_d = 1'b1;
                    cfg_rwn_d   = 1'b1;
                    cfg_addr_d  = REG_STATUS;
                    cfg_data_d  = 32'h0;
                    state_d     = S_POLL_RD;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_POLL_RD: begin
                if (cfg_ready_i) begin
                    ecc_d = cfg_data_i[5:4];
                    if (!status_busy || (timeout_hit && is_erase)) begin
                        timeout_d  = status_busy;
                        cfg_rwn_d  = 1'b1;
                        cfg_addr_d = REG_ISR;
                        state_d    = S_RD_ISR;
                    end else if (timeout_hit) begin
                        timeout_d  = 1'b1;
                        cfg_rwn_d  = 1'b0;
                        cfg_addr_d = (op_q == OP_READ) ? REG_RX_CFG : REG_TX_CFG;
                        cfg_data_d = CFG_CLR;
                        state_d    = S_ABORT;
                    end else begin
                        poll_d      = poll_inc;
                        cfg_valid_d = 1'b0;
                        cfg_rwn_d   = 1'b0;
                        gap_d       = 8'd0;
                        state_d     = S_POLL_WAIT;
                    end
                end
            end
            S_ABORT: begin
                if (cfg_ready_i) begin
                    cfg_rwn_d  = 1'b1;
                    cfg_addr_d = REG_ISR;
                    cfg_data_d = 32'h0;
                    state_d    = S_RD_ISR;
                end
            end
            S_RD_ISR: begin
                if (cfg_ready_i) begin
                    isr_d      = cfg_data_i[3:0];
                    cfg_rwn_d  = 1'b0;
                    cfg_addr_d = REG_ICR;
                    cfg_data_d = {28'h0, cfg_data_i[3:0]};
                    state_d    = S_WR_ICR;
                end
            end
            S_WR_ICR: begin
                if (cfg_ready_i) begin
                    cfg_valid_d = 1'b0;
                    cfg_data_d  = 32'h0;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            l2_q        <= '0;
            mram_q      <= '0;
            size_q      <= '0;
            step_q      <= 3'd0;
            gap_q       <= 8'd0;
            poll_q      <= 16'd0;
            cfg_valid_q <= 1'b0;
            cfg_rwn_q   <= 1'b0;
            cfg_addr_q  <= 5'd0;
            cfg_data_q  <= 32'h0;
            err_op_q    <= 1'b0;
            timeout_q   <= 1'b0;
            ecc_q       <= 2'b00;
            isr_q       <= 4'h0;
`ifdef MRAM_CFG_SEQ_TIMEOUT_EN
            limit_q     <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            l2_q        <= l2_d;
            mram_q      <= mram_d;
            size_q      <= size_d;
            step_q      <= step_d;
            gap_q       <= gap_d;
            poll_q      <= poll_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_rwn_q   <= cfg_rwn_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            err_op_q    <= err_op_d;
            timeout_q   <= timeout_d;
            ecc_q       <= ecc_d;
            isr_q       <= isr_d;
`ifdef MRAM_CFG_SEQ_TIMEOUT_EN
            limit_q     <= limit_d;
`endif
        end
    end

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign rsp_valid_o  = (state_q == S_RSP);
    assign rsp_status_o = {err_op_q, timeout_q, ecc_q, isr_q};
    assign cfg_valid_o  = cfg_valid_q;
    assign cfg_rwn_o    = cfg_rwn_q;
    assign cfg_addr_o   = cfg_addr_q;
    assign cfg_data_o   = cfg_data_q;

endmodule

// File: tb/tb_udma_mram_cfg_seq.sv
// Directed bench for udma_mram_cfg_seq with a behavioural config-register responder.
module tb_udma_mram_cfg_seq;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [11:0] cmd_l2_addr_i;
    logic [19:0] cmd_mram_addr_i;
    logic [15:0] cmd_size_i;
    logic [31:0] cmd_mode_i;
    logic [15:0] timeout_limit_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [7:0]  rsp_status_o;
    logic        busy_o;
    logic [31:0] cfg_data_o;
    logic [4:0]  cfg_addr_o;
    logic        cfg_valid_o;
    logic        cfg_rwn_o;
    logic [31:0] cfg_data_i;
    logic        cfg_ready_i;

    udma_mram_cfg_seq dut (
        .clk_i          (clk),
        .rstn_i         (rstn_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_op_i       (cmd_op_i),
        .cmd_l2_addr_i  (cmd_l2_addr_i),
        .cmd_mram_addr_i(cmd_mram_addr_i),
        .cmd_size_i     (cmd_size_i),
        .cmd_mode_i     (cmd_mode_i),
        .timeout_limit_i(timeout_limit_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_status_o   (rsp_status_o),
        .busy_o         (busy_o),
        .cfg_data_o     (cfg_data_o),
        .cfg_addr_o     (cfg_addr_o),
        .cfg_valid_o    (cfg_valid_o),
        .cfg_rwn_o      (cfg_rwn_o),
        .cfg_data_i     (cfg_data_i),
        .cfg_ready_i    (cfg_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        rwn;
        int          start;
        int          hold;
    } acc_t;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder configuration, written only by the stimulus process.
    int          delay_cfg   = 0;
    int          busy_polls  = 0;
    logic [31:0] status_busy = 32'h0;
    logic [31:0] status_idle = 32'h0;
    logic [31:0] isr_val     = 32'h0;
    logic        clr_req     = 1'b0;

    // Responder state, written only by the responder process.
    acc_t        log_q[$];
    int          status_reads = 0;
    int          unstable_cnt = 0;
    logic        in_acc = 1'b0;
    int          wait_cnt = 0;
    acc_t        cur;

    always @(negedge clk) begin
        cfg_ready_i = 1'b0;
        cfg_data_i  = 32'h0;
        if (clr_req) begin
            log_q.delete();
            status_reads = 0;
            unstable_cnt = 0;
        end
        if (!rstn_i) begin
            in_acc = 1'b0;
        end else if (cfg_valid_o) begin
            if (!in_acc) begin
                in_acc    = 1'b1;
                wait_cnt  = 0;
                cur.addr  = cfg_addr_o;
                cur.data  = cfg_data_o;
                cur.rwn   = cfg_rwn_o;
                cur.start = cyc;
            end else if (cfg_addr_o !== cur.addr || cfg_data_o !== cur.data || cfg_rwn_o !== cur.rwn) begin
                unstable_cnt++;
            end
            if (wait_cnt < delay_cfg) begin
                wait_cnt++;
            end else begin
                cfg_ready_i = 1'b1;
                in_acc      = 1'b0;
                cur.hold    = cyc - cur.start + 1;
                if (cur.rwn) begin
                    if (cur.addr == 5'h0A) begin
                        cfg_data_i = (status_reads < busy_polls) ? status_busy : status_idle;
                        status_reads++;
                    end else if (cur.addr == 5'h10) begin
                        cfg_data_i = isr_val;
                    end else begin
                        cfg_data_i = 32'hDEAD_BEEF;
                    end
                end
                log_q.push_back(cur);
            end
        end
    end

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic clear_log();
        clr_req = 1'b1;
        @(negedge clk);
        #1 clr_req = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [11:0] l2, input logic [19:0] mram,
                           input logic [15:0] size, input logic [31:0] mode, input logic [15:0] limit,
                           output int acc_cyc, output int rsp_cyc, output logic [7:0] status);
        int n;
        n = 0;
        while (!cmd_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        cmd_valid_i     = 1'b1;
        cmd_op_i        = op;
        cmd_l2_addr_i   = l2;
        cmd_mram_addr_i = mram;
        cmd_size_i      = size;
        cmd_mode_i      = mode;
        timeout_limit_i = limit;
        @(posedge clk);
        @(negedge clk);
        acc_cyc     = cyc;
        cmd_valid_i = 1'b0;
        checks_total++;
        if (busy_o !== 1'b1) $display("FAIL busy_after_accept: busy_o=%b want 1", busy_o);
        else checks_passed++;
        n = 0;
        while (!rsp_valid_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        rsp_cyc = cyc;
        status  = rsp_status_o;
        checks_total++;
        if (rsp_valid_o !== 1'b1) $display("FAIL rsp_arrival: rsp_valid_o=%b after %0d cycles", rsp_valid_o, n);
        else checks_passed++;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (3) @(negedge clk);
        checks_total++;
        if ({cmd_ready_o, cfg_valid_o, cfg_rwn_o, rsp_valid_o, busy_o, rsp_status_o, cfg_addr_o, cfg_data_o}
            !== {1'b1, 4'b0, 8'h0, 5'h0, 32'h0})
            $display("FAIL reset_outputs: ready=%b cfg_v=%b rwn=%b rsp_v=%b busy=%b st=%h a=%h d=%h want ready=1 others 0",
                     cmd_ready_o, cfg_valid_o, cfg_rwn_o, rsp_valid_o, busy_o, rsp_status_o, cfg_addr_o, cfg_data_o);
        else checks_passed++;
        rstn_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_prog();
        logic [37:0] exp[8] = '{{5'h0B, 32'h2, 1'b0}, {5'h04, 32'h100, 1'b0}, {5'h05, 32'h40, 1'b0},
                                {5'h08, 32'h1234, 1'b0}, {5'h06, 32'h10, 1'b0}, {5'h0A, 32'h0, 1'b1},
                                {5'h10, 32'h0, 1'b1}, {5'h12, 32'h2, 1'b0}};
        int a, r;
        logic [7:0] st;
        delay_cfg = 0; busy_polls = 0; status_idle = 32'h0; isr_val = 32'h2;
        clear_log();
        run_cmd(2'd1, 12'h100, 20'h01234, 16'h40, 32'h2, 16'd0, a, r, st);
        checks_total++;
        if (log_q.size() != 8) $display("FAIL prog_access_count: got %0d want 8", log_q.size());
        else checks_passed++;
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            checks_total++;
            if ({log_q[i].addr, log_q[i].data, log_q[i].rwn} !== exp[i])
                $display("FAIL prog_access_%0d: got a=%h d=%h rwn=%b want %h", i, log_q[i].addr, log_q[i].data, log_q[i].rwn, exp[i]);
            else checks_passed++;
        end
        checks_total++;
        if (st !== 8'h02) $display("FAIL prog_status: got %h want 02", st);
        else checks_passed++;
        checks_total++;
        if (r - a != 16) $display("FAIL prog_latency: got %0d want 16", r - a);
        else checks_passed++;
        checks_total++;
        if (unstable_cnt != 0) $display("FAIL prog_stable: got %0d changes want 0", unstable_cnt);
        else checks_passed++;
    endtask

    task automatic test_read_poll();
        logic [37:0] exp[11] = '{{5'h0B, 32'h7, 1'b0}, {5'h00, 32'hFFF, 1'b0}, {5'h01, 32'hFFFF, 1'b0},
                                 {5'h09, 32'hFFFFF, 1'b0}, {5'h02, 32'h10, 1'b0}, {5'h0A, 32'h0, 1'b1},
                                 {5'h0A, 32'h0, 1'b1}, {5'h0A, 32'h0, 1'b1}, {5'h0A, 32'h0, 1'b1},
                                 {5'h10, 32'h0, 1'b1}, {5'h12, 32'h1, 1'b0}};
        int a, r;
        logic [7:0] st;
        // Idle value keeps bit1 set: only bit2 is the READ busy flag.
        delay_cfg = 0; busy_polls = 3; status_busy = 32'h14; status_idle = 32'h12; isr_val = 32'h1;
        clear_log();
        run_cmd(2'd0, 12'hFFF, 20'hFFFFF, 16'hFFFF, 32'h7, 16'd0, a, r, st);
        checks_total++;
        if (log_q.size() != 11) $display("FAIL read_access_count: got %0d want 11", log_q.size());
        else checks_passed++;
        for (int i = 0; i < 11 && i < log_q.size(); i++) begin
            checks_total++;
            if ({log_q[i].addr, log_q[i].data, log_q[i].rwn} !== exp[i])
                $display("FAIL read_access_%0d: got a=%h d=%h rwn=%b want %h", i, log_q[i].addr, log_q[i].data, log_q[i].rwn, exp[i]);
            else checks_passed++;
        end
        for (int i = 6; i < 9 && i < log_q.size(); i++) begin
            checks_total++;
            if (log_q[i].start - log_q[i-1].start != 9)
                $display("FAIL read_poll_spacing_%0d: got %0d want 9", i, log_q[i].start - log_q[i-1].start);
            else checks_passed++;
        end
        checks_total++;
        if (st !== 8'h11) $display("FAIL read_status: got %h want 11", st);
        else checks_passed++;
    endtask

    task automatic test_erase_wait();
        logic [37:0] exp[7] = '{{5'h0B, 32'h5, 1'b0}, {5'h0C, 32'hABCD, 1'b0}, {5'h0D, 32'h3FF, 1'b0},
                                {5'h0F, 32'h1, 1'b0}, {5'h0A, 32'h0, 1'b1}, {5'h10, 32'h0, 1'b1},
                                {5'h12, 32'h4, 1'b0}};
        int a, r;
        logic [7:0] st;
        delay_cfg = 3; busy_polls = 0; status_idle = 32'h0; isr_val = 32'h4;
        clear_log();
        run_cmd(2'd2, 12'h055, 20'h5ABCD, 16'h13FF, 32'h5, 16'd0, a, r, st);
        checks_total++;
        if (log_q.size() != 7) $display("FAIL erase_access_count: got %0d want 7", log_q.size());
        else checks_passed++;
        for (int i = 0; i < 7 && i < log_q.size(); i++) begin
            checks_total++;
            if ({log_q[i].addr, log_q[i].data, log_q[i].rwn, log_q[i].hold} !== {exp[i], 32'sd4})
                $display("FAIL erase_access_%0d: got a=%h d=%h rwn=%b hold=%0d want %h hold 4",
                         i, log_q[i].addr, log_q[i].data, log_q[i].rwn, log_q[i].hold, exp[i]);
            else checks_passed++;
        end
        checks_total++;
        if (unstable_cnt != 0) $display("FAIL erase_stable: got %0d changes want 0", unstable_cnt);
        else checks_passed++;
        checks_total++;
        if (st !== 8'h04) $display("FAIL erase_status: got %h want 04", st);
        else checks_passed++;
        delay_cfg = 0;
    endtask

    task automatic test_bad_op();
        int a, r;
        logic [7:0] st;
        clear_log();
        run_cmd(2'd3, 12'h1, 20'h1, 16'h1, 32'h1, 16'd0, a, r, st);
        checks_total++;
        if (st !== 8'h80) $display("FAIL badop_status: got %h want 80", st);
        else checks_passed++;
        checks_total++;
        if (r - a != 0) $display("FAIL badop_latency: got %0d want 0", r - a);
        else checks_passed++;
        checks_total++;
        if (log_q.size() != 0) $display("FAIL badop_no_access: got %0d accesses want 0", log_q.size());
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        int a, r;
        logic [7:0] st;
        busy_polls = 0; status_idle = 32'h0; isr_val = 32'h8;
        clear_log();
        run_cmd(2'd1, 12'h010, 20'h00020, 16'h8, 32'h0, 16'd0, a, r, st);
        checks_total++;
        if ({cmd_ready_o, busy_o} !== 2'b10) $display("FAIL b2b_ready: ready=%b busy=%b want 1 0", cmd_ready_o, busy_o);
        else checks_passed++;
        run_cmd(2'd2, 12'h0, 20'h00010, 16'h2, 32'h0, 16'd0, a, r, st);
        checks_total++;
        if (st !== 8'h08) $display("FAIL b2b_status: got %h want 08", st);
        else checks_passed++;
        checks_total++;
        if (log_q.size() != 15) $display("FAIL b2b_access_count: got %0d want 15", log_q.size());
        else checks_passed++;
    endtask

`ifdef MRAM_CFG_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [37:0] exp[10] = '{{5'h0B, 32'h0, 1'b0}, {5'h04, 32'h1, 1'b0}, {5'h05, 32'h2, 1'b0},
                                 {5'h08, 32'h3, 1'b0}, {5'h06, 32'h10, 1'b0}, {5'h0A, 32'h0, 1'b1},
                                 {5'h0A, 32'h0, 1'b1}, {5'h06, 32'h40, 1'b0}, {5'h10, 32'h0, 1'b1},
                                 {5'h12, 32'h2, 1'b0}};
        int a, r;
        logic [7:0] st;
        busy_polls = 100000; status_busy = 32'h02; isr_val = 32'h2;
        clear_log();
        run_cmd(2'd1, 12'h1, 20'h3, 16'h2, 32'h0, 16'd2, a, r, st);
        checks_total++;
        if (log_q.size() != 10) $display("FAIL timeout_access_count: got %0d want 10", log_q.size());
        else checks_passed++;
        for (int i = 0; i < 10 && i < log_q.size(); i++) begin
            checks_total++;
            if ({log_q[i].addr, log_q[i].data, log_q[i].rwn} !== exp[i])
                $display("FAIL timeout_access_%0d: got a=%h d=%h rwn=%b want %h", i, log_q[i].addr, log_q[i].data, log_q[i].rwn, exp[i]);
            else checks_passed++;
        end
        checks_total++;
        if (st !== 8'h42) $display("FAIL timeout_status: got %h want 42", st);
        else checks_passed++;
    endtask
`else
    task automatic test_timeout();
        int a, r;
        logic [7:0] st;
        // Without the timeout feature the limit is ignored and polling runs until idle.
        busy_polls = 4; status_busy = 32'h02; status_idle = 32'h0; isr_val = 32'h2;
        clear_log();
        run_cmd(2'd1, 12'h1, 20'h3, 16'h2, 32'h0, 16'd2, a, r, st);
        checks_total++;
        if (log_q.size() != 12) $display("FAIL notimeout_access_count: got %0d want 12", log_q.size());
        else checks_passed++;
        checks_total++;
        if (log_q.size() > 10 && {log_q[9].addr, log_q[9].rwn, log_q[10].addr, log_q[10].rwn} !== {5'h0A, 1'b1, 5'h10, 1'b1})
            $display("FAIL notimeout_last_poll: got %h/%h want 0A then 10", log_q[9].addr, log_q[10].addr);
        else checks_passed++;
        checks_total++;
        if (st !== 8'h02) $display("FAIL notimeout_status: got %h want 02", st);
        else checks_passed++;
    endtask
`endif

    task automatic test_reset_mid_op();
        int a, r, n;
        logic [7:0] st;
        busy_polls = 100000; status_busy = 32'h02; isr_val = 32'h1;
        clear_log();
        cmd_valid_i = 1'b1; cmd_op_i = 2'd1; cmd_l2_addr_i = 12'h2; cmd_mram_addr_i = 20'h4;
        cmd_size_i = 16'h6; cmd_mode_i = 32'h0; timeout_limit_i = 16'd0;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        n = 0;
        while (log_q.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2 rstn_i = 1'b0;
        #1;
        checks_total++;
        if ({cfg_valid_o, cmd_ready_o, busy_o, rsp_valid_o} !== 4'b0100)
            $display("FAIL reset_mid_op: cfg_v=%b ready=%b busy=%b rsp_v=%b want 0 1 0 0", cfg_valid_o, cmd_ready_o, busy_o, rsp_valid_o);
        else checks_passed++;
        @(negedge clk);
        rstn_i = 1'b1;
        busy_polls = 0; status_idle = 32'h0;
        clear_log();
        run_cmd(2'd1, 12'h2, 20'h4, 16'h6, 32'h0, 16'd0, a, r, st);
        checks_total++;
        if (st !== 8'h01 || log_q.size() != 8) $display("FAIL reset_recover: status=%h count=%0d want 01 and 8", st, log_q.size());
        else checks_passed++;
    endtask

    initial begin
        cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_l2_addr_i = '0; cmd_mram_addr_i = '0;
        cmd_size_i = '0; cmd_mode_i = '0; timeout_limit_i = '0; rsp_ready_i = 1'b0;
        test_reset();
        test_prog();
        test_read_poll();
        test_erase_wait();
        test_bad_op();
        test_back_to_back();
        test_timeout();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
